fpna_config_chain: RTL and testbench

Double-buffered, parametrised configuration chain for the FPNA fabric. A multi-lane serial bitstream is shifted into a staging register, length-checked and, optionally, CRC-checked. It is then committed atomically into an active register that drives the neuron and routing configuration. The staging tail is exposed on `bs_out` so that several chips or tiles can be daisy-chained.

---
 rtl/fpna_config_chain.sv | 113 +++++++++++
 tb/tb_fpna_config_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpna_config_chain.sv
// Double-buffered FPNA configuration chain: multi-lane serial staging, length/CRC check, atomic commit.
// Optional CRC-8 trailer checking is enabled by defining FPNA_CFG_CRC_EN.
module fpna_config_chain #(
  parameter int CHAIN_LEN = 256,
  parameter int LANES     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 config_en,
  input  logic [LANES-1:0]     bs_in,
  output logic [LANES-1:0]     bs_out,
  input  logic                 commit,
  output logic [CHAIN_LEN-1:0] cfg_out,
  output logic                 cfg_valid,
  output logic                 commit_ok,
  output logic                 commit_err
);

`ifdef FPNA_CFG_CRC_EN
  localparam int CRC_W = 8;
`else
  localparam int CRC_W = 0;
`endif
  localparam int TOTAL = CHAIN_LEN + CRC_W;
  localparam int BEATS = TOTAL / LANES;
  localparam int CNT_W = $clog2(BEATS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BEATS + 1);

  logic [TOTAL-1:0]     r_stage;
  logic [TOTAL-1:0]     w_stage_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CHAIN_LEN-1:0] r_cfg;
  logic                 r_cfg_valid;
  logic                 r_ok;
  logic                 r_err;
  logic                 w_len_ok;
  logic                 w_crc_ok;
  logic                 w_accept;

  // Oldest bits sit at the top of the register; the newest beat enters at bit 0.
  generate
    if (TOTAL > LANES) begin : g_shift
      assign w_stage_nxt = {r_stage[TOTAL-LANES-1:0], bs_in};
    end else begin : g_load
      assign w_stage_nxt = bs_in;
    end
  endgenerate

`ifdef FPNA_CFG_CRC_EN
  logic [7:0] r_crc;

  // CRC-8, poly 0x07, MSB-first; bs_in[LANES-1] is the earliest bit of the beat.
  function automatic logic [7:0] crc8_beat(input logic [7:0] crc, input logic [LANES-1:0] beat);
    logic [7:0] c;
    c = crc;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (c[7] ^ beat[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign w_crc_ok = (r_crc == 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= 8'h00;
    end else if (commit) begin
      r_crc <= 8'h00;
    end else if (config_en) begin
      r_crc <= crc8_beat(r_crc, bs_in);
    end
  end
`else
  assign w_crc_ok = 1'b1;
`endif

  assign w_len_ok = (r_cnt == CNT_FULL);
  assign w_accept = !config_en && w_len_ok && w_crc_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage     <= '0;
      r_cnt       <= '0;
      r_cfg       <= '0;
      r_cfg_valid <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (config_en) r_stage <= w_stage_nxt;
      r_ok  <= commit && w_accept;
      r_err <= commit && !w_accept;
      // Every evaluation restarts the length count, so a held commit re-evaluates against zero.
      if (commit) begin
        r_cnt <= '0;
        if (w_accept) begin
          r_cfg       <= r_stage[TOTAL-1 -: CHAIN_LEN];
          r_cfg_valid <= 1'b1;
        end
      end else if (config_en && (r_cnt != CNT_SAT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bs_out     = r_stage[TOTAL-1 -: LANES];
  assign cfg_out    = r_cfg;
  assign cfg_valid  = r_cfg_valid;
  assign commit_ok  = r_ok;
  assign commit_err = r_err;

endmodule

// File: tb/tb_fpna_config_chain.sv
// Directed bench for fpna_config_chain; the CRC build (FPNA_CFG_CRC_EN) runs a CRC-specific sequence.
module tb_fpna_config_chain;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifndef FPNA_CFG_CRC_EN
  // Instance A: CHAIN_LEN=16, LANES=1
  logic        a_en = 1'b0;
  logic [0:0]  a_bs = '0;
  logic [0:0]  a_bs_out;
  logic        a_commit = 1'b0;
  logic [15:0] a_cfg;
  logic        a_valid, a_ok, a_err;

  // Instance B: CHAIN_LEN=16, LANES=4
  logic        b_en = 1'b0;
  logic [3:0]  b_bs = '0;
  logic [3:0]  b_bs_out;
  logic        b_commit = 1'b0;
  logic [15:0] b_cfg;
  logic        b_valid, b_ok, b_err;

  fpna_config_chain #(.CHAIN_LEN(16), .LANES(1)) u_a (
    .clk(clk), .reset(reset), .config_en(a_en), .bs_in(a_bs), .bs_out(a_bs_out),
    .commit(a_commit), .cfg_out(a_cfg), .cfg_valid(a_valid),
    .commit_ok(a_ok), .commit_err(a_err));

  fpna_config_chain #(.CHAIN_LEN(16), .LANES(4)) u_b (
    .clk(clk), .reset(reset), .config_en(b_en), .bs_in(b_bs), .bs_out(b_bs_out),
    .commit(b_commit), .cfg_out(b_cfg), .cfg_valid(b_valid),
    .commit_ok(b_ok), .commit_err(b_err));

  task automatic a_shift(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      a_en = 1'b1;
      a_bs = val[15 - (i % 16)];
      @(posedge clk); #1;
    end
    a_en = 1'b0;
  endtask

  task automatic a_pulse_commit();
    a_commit = 1'b1;
    @(posedge clk); #1;
    a_commit = 1'b0;
  endtask

  task automatic b_beat(input logic [3:0] v);
    b_en = 1'b1;
    b_bs = v;
    @(posedge clk); #1;
    b_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg", 32'(a_cfg), 32'h0);
    chk("rst_valid", 32'(a_valid), 32'h0);
    chk("rst_ok", 32'(a_ok), 32'h0);
    chk("rst_err", 32'(a_err), 32'h0);
    chk("rst_bs_out", 32'(a_bs_out), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic load 0xA5C3
    a_shift(16'hA5C3, 16);
    chk("a5c3_bs_out", 32'(a_bs_out), 32'h1);
    chk("a5c3_pre_valid", 32'(a_valid), 32'h0);
    a_pulse_commit();
    chk("a5c3_cfg", 32'(a_cfg), 32'hA5C3);
    chk("a5c3_valid", 32'(a_valid), 32'h1);
    chk("a5c3_ok", 32'(a_ok), 32'h1);
    chk("a5c3_err", 32'(a_err), 32'h0);
    @(posedge clk); #1;
    chk("a5c3_ok_drop", 32'(a_ok), 32'h0);

    // Short stream, then a held commit re-evaluates against an empty count
    a_shift(16'hFFFF, 15);
    a_commit = 1'b1;
    @(posedge clk); #1;
    chk("short_err", 32'(a_err), 32'h1);
    chk("short_ok", 32'(a_ok), 32'h0);
    chk("short_cfg", 32'(a_cfg), 32'hA5C3);
    @(posedge clk); #1;
    a_commit = 1'b0;
    chk("recommit_err", 32'(a_err), 32'h1);
    chk("recommit_cfg", 32'(a_cfg), 32'hA5C3);
    @(posedge clk); #1;
    chk("recommit_err_drop", 32'(a_err), 32'h0);

    // Long stream (17 beats)
    a_shift(16'h0000, 17);
    a_pulse_commit();
    chk("long_err", 32'(a_err), 32'h1);
    chk("long_cfg", 32'(a_cfg), 32'hA5C3);
    chk("long_valid", 32'(a_valid), 32'h1);

    // Correct reload of a different pattern
    a_shift(16'h0F0F, 16);
    a_pulse_commit();
    chk("0f0f_ok", 32'(a_ok), 32'h1);
    chk("0f0f_cfg", 32'(a_cfg), 32'h0F0F);

    // Commit coincident with config_en: rejected, shift still happens
    a_shift(16'h3C3C, 15);
    chk("en_commit_pre_bs", 32'(a_bs_out), 32'h1);
    a_en = 1'b1;
    a_bs = 1'b0;
    a_commit = 1'b1;
    @(posedge clk); #1;
    a_en = 1'b0;
    a_commit = 1'b0;
    chk("en_commit_err", 32'(a_err), 32'h1);
    chk("en_commit_ok", 32'(a_ok), 32'h0);
    chk("en_commit_cfg", 32'(a_cfg), 32'h0F0F);
    chk("en_commit_shifted", 32'(a_bs_out), 32'h0);

    // Four-lane load 0x1234
    b_beat(4'h1);
    b_beat(4'h2);
    b_beat(4'h3);
    b_beat(4'h4);
    b_commit = 1'b1;
    @(posedge clk); #1;
    b_commit = 1'b0;
    chk("lanes4_ok", 32'(b_ok), 32'h1);
    chk("lanes4_cfg", 32'(b_cfg), 32'h1234);
    chk("lanes4_valid", 32'(b_valid), 32'h1);
    chk("lanes4_bs_out_first", 32'(b_bs_out), 32'h1);
    b_beat(4'h5);
    chk("lanes4_bs_out_next", 32'(b_bs_out), 32'h2);
    chk("lanes4_cfg_hold", 32'(b_cfg), 32'h1234);

    // Reset in the middle of a load
    a_shift(16'hFFFF, 8);
    reset = 1'b1;
    #1;
    chk("midrst_a_cfg", 32'(a_cfg), 32'h0);
    chk("midrst_a_valid", 32'(a_valid), 32'h0);
    chk("midrst_b_cfg", 32'(b_cfg), 32'h0);
    chk("midrst_b_bs_out", 32'(b_bs_out), 32'h0);
    chk("midrst_b_valid", 32'(b_valid), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    a_pulse_commit();
    chk("postrst_empty_err", 32'(a_err), 32'h1);
    chk("postrst_empty_valid", 32'(a_valid), 32'h0);
    a_shift(16'h5AA5, 16);
    a_pulse_commit();
    chk("reload_ok", 32'(a_ok), 32'h1);
    chk("reload_cfg", 32'(a_cfg), 32'h5AA5);
    chk("reload_valid", 32'(a_valid), 32'h1);

    // Reset during the commit_ok pulse
    reset = 1'b1;
    #1;
    chk("pulserst_ok", 32'(a_ok), 32'h0);
    chk("pulserst_valid", 32'(a_valid), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

`else
  // CRC build: CHAIN_LEN=8, LANES=1, staging of 16 bits
  logic        c_en = 1'b0;
  logic [0:0]  c_bs = '0;
  logic [0:0]  c_bs_out;
  logic        c_commit = 1'b0;
  logic [7:0]  c_cfg;
  logic        c_valid, c_ok, c_err;

  fpna_config_chain #(.CHAIN_LEN(8), .LANES(1)) u_c (
    .clk(clk), .reset(reset), .config_en(c_en), .bs_in(c_bs), .bs_out(c_bs_out),
    .commit(c_commit), .cfg_out(c_cfg), .cfg_valid(c_valid),
    .commit_ok(c_ok), .commit_err(c_err));

  task automatic c_shift(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      c_en = 1'b1;
      c_bs = val[15 - (i % 16)];
      @(posedge clk); #1;
    end
    c_en = 1'b0;
  endtask

  task automatic c_pulse_commit();
    c_commit = 1'b1;
    @(posedge clk); #1;
    c_commit = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cfg", 32'(c_cfg), 32'h0);
    chk("rst_valid", 32'(c_valid), 32'h0);
    chk("rst_ok", 32'(c_ok), 32'h0);
    chk("rst_err", 32'(c_err), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Payload 0x01, CRC 0x07
    c_shift(16'h0107, 16);
    chk("crc01_bs_out", 32'(c_bs_out), 32'h0);
    c_pulse_commit();
    chk("crc01_ok", 32'(c_ok), 32'h1);
    chk("crc01_err", 32'(c_err), 32'h0);
    chk("crc01_cfg", 32'(c_cfg), 32'h01);
    chk("crc01_valid", 32'(c_valid), 32'h1);

    // Payload 0xA5, CRC 0x72
    c_shift(16'hA572, 16);
    chk("crca5_bs_out", 32'(c_bs_out), 32'h1);
    c_pulse_commit();
    chk("crca5_ok", 32'(c_ok), 32'h1);
    chk("crca5_cfg", 32'(c_cfg), 32'hA5);

    // Corrupted trailer
    c_shift(16'h0106, 16);
    c_pulse_commit();
    chk("badcrc_err", 32'(c_err), 32'h1);
    chk("badcrc_ok", 32'(c_ok), 32'h0);
    chk("badcrc_cfg", 32'(c_cfg), 32'hA5);

    // CRC state clears on the rejected commit, so a good frame is accepted next
    c_shift(16'h0107, 16);
    c_pulse_commit();
    chk("crc_after_bad_ok", 32'(c_ok), 32'h1);
    chk("crc_after_bad_cfg", 32'(c_cfg), 32'h01);

    // Wrong length with a CRC-valid prefix
    c_shift(16'hA572, 15);
    c_pulse_commit();
    chk("crc_short_err", 32'(c_err), 32'h1);
    chk("crc_short_cfg", 32'(c_cfg), 32'h01);

    // Reset mid-load, then a full reload
    c_shift(16'hA572, 8);
    reset = 1'b1;
    #1;
    chk("midrst_cfg", 32'(c_cfg), 32'h0);
    chk("midrst_valid", 32'(c_valid), 32'h0);
    chk("midrst_bs_out", 32'(c_bs_out), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    c_shift(16'hA572, 16);
    c_pulse_commit();
    chk("reload_ok", 32'(c_ok), 32'h1);
    chk("reload_cfg", 32'(c_cfg), 32'hA5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
`endif

endmodule
